// File: rtl/cdr_pkg.sv
// rtl/cdr_pkg.sv - shared CDR constants and phase-detector state type
package cdr_pkg;

    typedef enum logic [0:0] {
        ACQ   = 1'b0,
        TRACK = 1'b1
    } pd_state_t;

    // Period bounds shared with the period divider.
    localparam int NB_P_RESET = 25;
    localparam int NB_P_MIN   = 23;
    localparam int NB_P_MAX   = 27;

endpackage

// File: rtl/cdr_sync2.sv
// rtl/cdr_sync2.sv - two-flop synchronizer with registered-history edge detect
module cdr_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_data,
    output logic o_d_s,
    output logic o_edge
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= i_data;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign o_d_s  = sync_q;
    assign o_edge = sync_q ^ prev_q;

endmodule

// File: rtl/cdr_phase_detector.sv
// rtl/cdr_phase_detector.sv - Alexander bang-bang phase detector feeding the CDR period divider
module cdr_phase_detector #(
    parameter int CNT_W    = 6,
    parameter int NB_P_MIN = cdr_pkg::NB_P_MIN,
    parameter int NB_P_MAX = cdr_pkg::NB_P_MAX,
    parameter int VOTE_LEN = 4,
    parameter int LOCK_CNT = 3,
    parameter int MAX_RUN  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_data,
    input  logic [CNT_W-1:0] i_nb_P,
    output logic             o_T,
    output logic             o_E,
    output logic             o_dec_valid,
    output logic             o_bit,
    output logic             o_bit_valid,
    output logic             o_locked
);
    import cdr_pkg::*;

    localparam int VW = $clog2(VOTE_LEN) + 2;
    localparam int TW = $clog2(VOTE_LEN + 1);
    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam int RW = $clog2(MAX_RUN + 1);
    localparam logic signed [VW-1:0] V_ONE = VW'(1);

    logic d_s;
    logic edge_s;

    cdr_sync2 u_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_data (i_data),
        .o_d_s  (d_s),
        .o_edge (edge_s)
    );

    pd_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       p_q, p_d;
    logic                   a_q, a_d, a_valid_q, a_valid_d, b_q, b_d;
    logic signed [VW-1:0]   vote_q, vote_d, vote_new;
    logic [TW-1:0]          tcnt_q, tcnt_d, tcnt_new;
    logic [RW-1:0]          run_q, run_d;
    logic [LW-1:0]          lockcnt_q, lockcnt_d;
    logic                   prev_e_q, prev_e_d, prev_e_valid_q, prev_e_valid_d;
    logic                   t_q, t_d, e_q, e_d, dec_valid_q, dec_valid_d;
    logic                   bit_q, bit_d, bit_valid_q, bit_valid_d, locked_q, locked_d;
    logic [CNT_W-1:0]       nb_p_clamped;
    logic                   is_centre, is_wrap;

    always_comb begin
        nb_p_clamped = i_nb_P;
        if (i_nb_P < CNT_W'(NB_P_MIN)) begin
            nb_p_clamped = CNT_W'(NB_P_MIN);
        end else if (i_nb_P > CNT_W'(NB_P_MAX)) begin
            nb_p_clamped = CNT_W'(NB_P_MAX);
        end
    end

    assign is_centre = (state_q == TRACK) && (cnt_q == (p_q >> 1));
    assign is_wrap   = (state_q == TRACK) && (cnt_q == p_q - 1'b1);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        p_d            = p_q;
        a_d            = a_q;
        a_valid_d      = a_valid_q;
        b_d            = b_q;
        vote_new       = vote_q;
        tcnt_new       = tcnt_q;
        vote_d         = vote_q;
        tcnt_d         = tcnt_q;
        run_d          = run_q;
        lockcnt_d      = lockcnt_q;
        prev_e_d       = prev_e_q;
        prev_e_valid_d = prev_e_valid_q;
        t_d            = t_q;
        e_d            = e_q;
        dec_valid_d    = 1'b0;
        bit_d          = bit_q;
        bit_valid_d    = 1'b0;
        locked_d       = locked_q;

        if (state_q == ACQ) begin
            cnt_d = '0;
            if (edge_s) begin
                cnt_d     = CNT_W'(1);
                a_valid_d = 1'b0;
                run_d     = '0;
                state_d   = TRACK;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (is_wrap) begin
                cnt_d = '0;
                p_d   = nb_p_clamped;
                b_d   = d_s;
            end
            if (is_centre) begin
                bit_d       = d_s;
                bit_valid_d = 1'b1;
                t_d         = 1'b0;
                a_d         = d_s;
                a_valid_d   = 1'b1;
                // Edge sample still matching the old symbol means the transition came late: we sample early.
                if (a_valid_q && (a_q != d_s)) begin
                    vote_new = (b_q == a_q) ? (vote_q + V_ONE) : (vote_q - V_ONE);
                    tcnt_new = tcnt_q + 1'b1;
                    run_d    = '0;
                end else begin
                    run_d = run_q + 1'b1;
                end
                vote_d = vote_new;
                tcnt_d = tcnt_new;
                if (tcnt_new == TW'(VOTE_LEN)) begin
                    t_d         = (vote_new != 0);
                    e_d         = (vote_new > 0);
                    dec_valid_d = 1'b1;
                    vote_d      = '0;
                    tcnt_d      = '0;
                    if ((vote_new == 0) || (prev_e_valid_q && ((vote_new > 0) != prev_e_q))) begin
                        lockcnt_d = (lockcnt_q == LW'(LOCK_CNT)) ? lockcnt_q : lockcnt_q + 1'b1;
                    end else begin
                        lockcnt_d = '0;
                    end
                    if (vote_new != 0) begin
                        prev_e_d       = (vote_new > 0);
                        prev_e_valid_d = 1'b1;
                    end
                    locked_d = (lockcnt_d == LW'(LOCK_CNT));
                end
                if (run_d == RW'(MAX_RUN)) begin
                    state_d   = ACQ;
                    cnt_d     = '0;
                    locked_d  = 1'b0;
                    lockcnt_d = '0;
                    vote_d    = '0;
                    tcnt_d    = '0;
                    t_d       = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= ACQ;
            cnt_q          <= '0;
            p_q            <= CNT_W'(NB_P_RESET);
            a_q            <= 1'b0;
            a_valid_q      <= 1'b0;
            b_q            <= 1'b0;
            vote_q         <= '0;
            tcnt_q         <= '0;
            run_q          <= '0;
            lockcnt_q      <= '0;
            prev_e_q       <= 1'b0;
            prev_e_valid_q <= 1'b0;
            t_q            <= 1'b0;
            e_q            <= 1'b0;
            dec_valid_q    <= 1'b0;
            bit_q          <= 1'b0;
            bit_valid_q    <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            p_q            <= p_d;
            a_q            <= a_d;
            a_valid_q      <= a_valid_d;
            b_q            <= b_d;
            vote_q         <= vote_d;
            tcnt_q         <= tcnt_d;
            run_q          <= run_d;
            lockcnt_q      <= lockcnt_d;
            prev_e_q       <= prev_e_d;
            prev_e_valid_q <= prev_e_valid_d;
            t_q            <= t_d;
            e_q            <= e_d;
            dec_valid_q    <= dec_valid_d;
            bit_q          <= bit_d;
            bit_valid_q    <= bit_valid_d;
            locked_q       <= locked_d;
        end
    end

    assign o_T         = t_q;
    assign o_E         = e_q;
    assign o_dec_valid = dec_valid_q;
    assign o_bit       = bit_q;
    assign o_bit_valid = bit_valid_q;
    assign o_locked    = locked_q;

endmodule

// File: tb/tb_cdr_phase_detector.sv
// tb/tb_cdr_phase_detector.sv - directed self-checking bench for cdr_phase_detector
module tb_cdr_phase_detector;
    import cdr_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_data = 1'b0;
    logic [5:0] i_nb_P = 6'd25;
    logic       o_T, o_E, o_dec_valid, o_bit, o_bit_valid, o_locked;

    cdr_phase_detector dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_data      (i_data),
        .i_nb_P      (i_nb_P),
        .o_T         (o_T),
        .o_E         (o_E),
        .o_dec_valid (o_dec_valid),
        .o_bit       (o_bit),
        .o_bit_valid (o_bit_valid),
        .o_locked    (o_locked)
    );

    always #10 i_clk = ~i_clk;

    int   checks = 0;
    int   errors = 0;
    int   dec_cnt, bv_cnt, t_len, t_hold, n;
    logic dec_T, dec_E, hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        dec_cnt = 0; bv_cnt = 0; t_len = 0; t_hold = 0; dec_T = 1'b0; dec_E = 1'b0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        if (o_dec_valid) begin
            dec_cnt++;
            dec_T = o_T;
            dec_E = o_E;
        end
        if (o_bit_valid) bv_cnt++;
        if (o_T) t_len++;
        else if (t_len != 0) begin
            t_hold = t_len;
            t_len  = 0;
        end
    endtask

    task automatic reset_dut(input int cycles);
        i_data = 1'b0;
        i_rst  = 1'b1;
        repeat (cycles) tick();
        i_rst = 1'b0;
        clear_mon();
    endtask

    task automatic send_syms(input int len_a, input int len_b, input int nsym);
        for (int s = 0; s < nsym; s++) begin
            i_data = ~i_data;
            repeat ((s % 2 == 0) ? len_a : len_b) tick();
        end
    endtask

    // Symbol lengths 24,26,... put every other transition just before the edge sample: each window ties.
    task automatic lock_run();
        int nxt;
        int s;
        nxt = 0;
        s   = 0;
        for (int c = 0; c < 1000; c++) begin
            if (o_locked) break;
            if (c == nxt) begin
                i_data = ~i_data;
                nxt += (s % 2 == 0) ? 24 : 26;
                s++;
            end
            tick();
        end
    endtask

    initial begin
        clear_mon();
        i_rst = 1'b1;
        i_data = 1'b1; tick();
        i_data = 1'b0; tick();
        i_data = 1'b1; tick();
        i_data = 1'b0;
        check("reset_outputs", {o_T, o_E, o_dec_valid, o_bit, o_bit_valid, o_locked}, 6'b0);
        i_rst = 1'b0;
        clear_mon();
        repeat (50) tick();
        check("idle_state", dut.state_q, ACQ);
        check("idle_cnt", dut.cnt_q, 6'd0);
        check("idle_p", dut.p_q, 6'd25);
        check("idle_no_bit_valid", bv_cnt, 0);
        check("idle_outputs", {o_T, o_E, o_dec_valid, o_bit, o_bit_valid, o_locked}, 6'b0);

        i_data = 1'b1;
        n = 0;
        while (!o_bit_valid && n < 100) begin
            tick();
            n++;
        end
        check("acq_latency", n, 15);
        check("acq_bit", o_bit, 1'b1);
        check("acq_state", dut.state_q, TRACK);

        reset_dut(2);
        send_syms(26, 26, 7);
        check("early_dec_cnt", dec_cnt, 1);
        check("early_T", dec_T, 1'b1);
        check("early_E", dec_E, 1'b1);
        check("early_T_hold", t_hold, 25);

        reset_dut(2);
        send_syms(24, 24, 7);
        check("late_dec_cnt", dec_cnt, 1);
        check("late_T", dec_T, 1'b1);
        check("late_E", dec_E, 1'b0);

        reset_dut(2);
        lock_run();
        check("lock_locked", o_locked, 1'b1);
        check("lock_dec_cnt", dec_cnt, 3);
        check("lock_tie_T", dec_T, 1'b0);
        check("lock_bit_valid", o_bit_valid, 1'b1);

        hold   = i_data;
        bv_cnt = 0;
        i_nb_P = 6'd40;
        repeat (30) tick();
        check("clamp_p", dut.p_q, 6'd27);
        n = 0;
        while (o_locked && n < 1000) begin
            tick();
            n++;
        end
        check("timeout_locked", o_locked, 1'b0);
        check("timeout_state", dut.state_q, ACQ);
        check("timeout_T", o_T, 1'b0);
        check("timeout_bit_kept", o_bit, hold);
        check("timeout_symbols", bv_cnt, 16);
        repeat (60) tick();
        check("acq_no_more_bits", bv_cnt, 16);

        i_nb_P = 6'd25;
        reset_dut(2);
        lock_run();
        check("relock_locked", o_locked, 1'b1);
        repeat (22) tick();
        check("midsym_cnt", dut.cnt_q, 6'd10);
        check("midsym_locked_before", o_locked, 1'b1);
        i_rst = 1'b1;
        tick();
        check("midsym_outputs", {o_T, o_E, o_dec_valid, o_bit, o_bit_valid, o_locked}, 6'b0);
        check("midsym_p", dut.p_q, 6'd25);
        check("midsym_state", dut.state_q, ACQ);
        i_rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdr_phase_detector.md
Name: cdr_phase_detector

Overview:
- Bang-bang (Alexander) phase detector directly upstream of the CDR period divider.
- Oversamples the incoming serial chip stream on i_clk (50 MHz) with a phase counter whose period is the divider's current o_nb_P.
- Takes one centre sample and one edge sample per symbol, and majority-votes early/late over a window of transitions.
- Drives the divider's i_T / i_E inputs; also emits recovered bits and a lock flag.

Parameters:
- CNT_W, 6, width of the period count and phase counter.
- NB_P_MIN, 23, lower clamp on the latched period.
- NB_P_MAX, 27, upper clamp on the latched period.
- VOTE_LEN, 4, transitions accumulated per early/late decision.
- LOCK_CNT, 3, consecutive "dithering" decisions required to assert lock.
- MAX_RUN, 16, symbols without a transition before falling back to acquisition.

Ports:
- i_clk  in  1  system clock, 50 MHz.
- i_rst  in  1  synchronous, active-high reset.
- i_data  in  1  asynchronous serial input.
- i_nb_P  in  CNT_W  current period in clocks, from the divider.
- o_T  out  1  valid correction request (transition-based decision non-tied).
- o_E  out  1  direction of the correction: 1 = sampling early (lengthen period), 0 = late (shorten period).
- o_dec_valid  out  1  one-cycle pulse per completed vote window.
- o_bit  out  1  recovered bit.
- o_bit_valid  out  1  one-cycle pulse when o_bit updates.
- o_locked  out  1  lock indicator.

Behaviour:
- Reset values: all outputs 0; state ACQ; cnt=0; P=25; vote=0; tcnt=0; lockcnt=0.
- Reset mid-operation: all state abandons immediately on the next clock edge.
- Input sync: i_data passes through a 2-flop synchronizer to produce d_s; d_p = d_s delayed one cycle; edge = d_s ^ d_p.
- State ACQ:
  - cnt held at 0.
  - On edge: cnt<=1, A_valid<=0, go to TRACK.
- State TRACK, phase counter:
  - cnt increments each cycle.
  - At cnt==P-1: cnt<=0 and P<=clamp(i_nb_P, NB_P_MIN, NB_P_MAX). i_nb_P is sampled only here.
- Centre event (cnt==P>>1):
  - C<=d_s; o_bit<=d_s; o_bit_valid pulses.
  - If A_valid and A!=C (transition):
    - vote += (B==A) ? +1 : -1; tcnt++; run<=0.
  - Else: run++.
  - A<=C; A_valid<=1.
  - o_T cleared at this event unless a new decision is made at the same event.
- Edge event (cnt==P-1): B<=d_s.
- Decision, when tcnt reaches VOTE_LEN (evaluated on the updated values):
  - o_T<=(vote!=0); o_E<=(vote>0); o_dec_valid pulses.
  - vote<=0; tcnt<=0.
  - o_T/o_E are held for exactly one symbol (until the next centre event), so the divider sees one update strobe per decision.
- Vote arithmetic: signed, width clog2(VOTE_LEN)+2. The magnitude never exceeds VOTE_LEN, so no saturation is needed.
- Lock tracking, on each decision:
  - lockcnt++ (saturating at LOCK_CNT) if the decision is a tie, or if its o_E differs from the previous non-tied decision's o_E.
  - Otherwise lockcnt<=0.
  - o_locked = (lockcnt==LOCK_CNT), registered.
- Timeout: if run reaches MAX_RUN, go to ACQ and clear o_locked, lockcnt, vote, tcnt, o_T. o_bit keeps its last value.
- Simultaneous events: a reset at any event wins.

Decomposition:
- Package cdr_pkg holds:
  - typedef enum {ACQ, TRACK} pd_state_t;
  - constants NB_P_RESET=25, NB_P_MIN, NB_P_MAX.
  - These are shared with the divider, replacing its literals 23/25/27.
- One sub-module: cdr_sync2, the 2-flop synchronizer plus edge detector.

Test Plan:
- Reset/idle: i_rst high for 3 cycles with i_data toggling, then idle with i_data constant → all outputs 0, state ACQ, o_bit_valid never pulses.
- Acquisition: with i_nb_P=25, i_data 0→1 (edge, then P=25 clocks/symbol) → first o_bit_valid 12 cycles after cnt=1 starts, o_bit=1.
- Early/late:
  - Alternating 1010 data with period 26 clocks, i_nb_P=25 → after 4 transitions o_dec_valid pulses, o_T=1, o_E=1, o_T held 25 cycles.
  - Same pattern with period 24 → o_E=0.
- Tie and lock: alternating pattern at exactly 25 clocks/symbol → decisions dither or tie; o_locked=1 after the 3rd qualifying decision.
- Clamp and timeout:
  - i_nb_P=40 → latched P=27 at the next wrap.
  - Hold i_data constant for 16 symbols → return to ACQ, o_locked and o_T drop to 0.
- Reset mid-symbol: assert i_rst at cnt=10 in TRACK with o_locked=1 → next cycle all outputs are 0 and P=25.
